data_mem_responder: RTL
=======================

# data_mem_responder

Responder end of the core's data-memory port. It accepts the address, write data, read/write enables and 2-bit size mask driven by the load/store stage, and performs byte-lane-merged writes into an on-chip word array. It returns read data right-justified after a parameterised latency and flags illegal accesses. It sits between the load/store stage and the data RAM, replacing the bare RAM model.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two.
- `READ_LATENCY`, default 1: cycles from read acceptance to `o_data_mem_read_valid`; legal range 1..4.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_data_mem_addr`  in  32  byte address.
- `i_data_mem_write_data`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `i_data_mem_read_en`  in  1  read request.
- `i_data_mem_write_en`  in  1  write request.
- `i_data_mem_data_mask`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- `o_data_mem_read_data`  out  32  load data, right-justified, upper bits zero.
- `o_data_mem_read_valid`  out  1  one-cycle pulse when `o_data_mem_read_data` is new.
- `o_data_mem_busy`  out  1  read in flight; requests are ignored while high.
- `o_data_mem_fault`  out  1  one-cycle pulse for an illegal access.

## Operation
- **Accept:** a request is accepted on a rising edge where `(read_en | write_en) & !busy`. Requests seen while busy are dropped; the requester must hold them.
- **Legality:** an access is illegal if any of the following holds. Illegal accesses never modify the memory.
  - mask is 11;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠00;
  - `addr - BASE_ADDR >= DEPTH_WORDS*4`, unsigned, with 32-bit wrap;
  - `read_en` and `write_en` are both high.
- **Word index:** `(addr - BASE_ADDR) >> 2`, truncated to log2(DEPTH_WORDS) bits.
- **Write lanes:**
  - byte: lane addr[1:0] receives write_data[7:0];
  - half: lanes {addr[1],0} and {addr[1],1} receive write_data[15:0];
  - word: all four lanes.
  - Unselected lanes keep their contents.
- **Read extraction:** the addressed word is shifted right by `8*addr[1:0]`. Byte keeps [7:0], half keeps [15:0], and the rest is zero-filled. Sign extension belongs to the load/store stage.
- **Read pipeline:** a shift register of depth `READ_LATENCY` carries valid, fault and the data (or the extracted-lane offset). An illegal read delivers data 0 with both `o_data_mem_read_valid` and `o_data_mem_fault` high.
- **Data hold:** `o_data_mem_read_data` holds its last value between reads.
- **Memory reset:** memory contents are not reset. Initial contents are undefined; simulation may preload them with `$readmemh`.

## Timing
- **Reset values:** `o_data_mem_read_data`=0, `o_data_mem_read_valid`=0, `o_data_mem_busy`=0, `o_data_mem_fault`=0. The read pipeline is flushed.
- **Reset mid-read:** the pending read is discarded and no `o_data_mem_read_valid` is produced after `rst_n` deasserts.
- **Write:** committed at the accepting edge, accepted at edge k.
  - Legal write: a read accepted at edge k+1 returns the new data.
  - Illegal write: `o_data_mem_fault` pulses in cycle k+1, and `o_data_mem_busy` is never raised.
- **Read:** accepted at edge k.
  - `o_data_mem_read_valid` (and the fault, if illegal) is high for exactly the one cycle following edge k+`READ_LATENCY`.
  - `o_data_mem_busy` is high for cycles k+1 .. k+`READ_LATENCY`-1, so it never asserts when `READ_LATENCY`=1.
  - A new request may be accepted at the edge that ends the last busy cycle. Back-to-back reads with `READ_LATENCY`=1 give one result per cycle.
- **Throughput:** one access per cycle when not busy. There is no internal queuing.

## Test plan
- **Write/readback, `READ_LATENCY`=1, `BASE_ADDR`=0:**
  - stimulus: word-write 32'hDEADBEEF at 0x10, then read byte at 0x13, half at 0x12, word at 0x10 on consecutive cycles;
  - required: read_data 32'h000000DE, 32'h0000DEAD, 32'hDEADBEEF in successive cycles, each with read_valid=1.
- **Byte-lane merge:**
  - stimulus: word-write 32'h11223344 at 0x20, byte-write 32'hFFFFFFAA at 0x21, half-write 32'h0000BBCC at 0x22;
  - required: word read at 0x20 returns 32'hBBCCAA44.
- **Misaligned/reserved:**
  - stimulus: half-write at 0x31, word-read at 0x32, mask 11 read at 0x30;
  - required: fault pulses each time; the reads return 0 with read_valid; word 0x30 is unchanged.
- **Range and conflict, `BASE_ADDR`=0x1000:**
  - stimulus 1: a read at 0x0FFC, and a read at 0x1000+`DEPTH_WORDS`*4 → each raises fault;
  - stimulus 2: read_en and write_en high together at 0x1000 → fault, and word 0x1000 is unchanged.
- **`READ_LATENCY`=3:**
  - stimulus: read at edge k while a second read is held from k+1;
  - required: busy high for cycles k+1 and k+2; read_valid high only in cycle k+3; the second read is accepted at edge k+3 and valid in cycle k+6.
- **Reset mid-read:**
  - stimulus: `READ_LATENCY`=3, assert `rst_n`=0 in cycle k+1 after a read at edge k;
  - required: all outputs go to 0 immediately, and no read_valid appears after release.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Data-memory port between the load/store stage (master) and the responder (slave).
interface data_mem_responder_if;
  logic [31:0] i_data_mem_addr;
  logic [31:0] i_data_mem_write_data;
  logic        i_data_mem_read_en;
  logic        i_data_mem_write_en;
  logic [1:0]  i_data_mem_data_mask;
  logic [31:0] o_data_mem_read_data;
  logic        o_data_mem_read_valid;
  logic        o_data_mem_busy;
  logic        o_data_mem_fault;

  modport master (
    output i_data_mem_addr, i_data_mem_write_data, i_data_mem_read_en,
           i_data_mem_write_en, i_data_mem_data_mask,
    input  o_data_mem_read_data, o_data_mem_read_valid, o_data_mem_busy,
           o_data_mem_fault
  );

  modport slave (
    input  i_data_mem_addr, i_data_mem_write_data, i_data_mem_read_en,
           i_data_mem_write_en, i_data_mem_data_mask,
    output o_data_mem_read_data, o_data_mem_read_valid, o_data_mem_busy,
           o_data_mem_fault
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-lane-merged writes into a word array, right-justified
// reads after READ_LATENCY cycles, and fault reporting for illegal accesses.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] widx;
  size_e         size;
  logic          rd;
  logic          wr;
  logic          illegal;
  logic          in_flight;
  logic          accept;
  logic [3:0]    lane_en;
  logic [31:0]   wr_word;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_extract;

  logic          pv [READ_LATENCY];
  logic          pf [READ_LATENCY];
  logic [31:0]   pd [READ_LATENCY];
  logic          wr_fault_q;

  // Decode the request: word offset, access size and legality.
  always_comb begin
    rd      = bus.i_data_mem_read_en;
    wr      = bus.i_data_mem_write_en;
    off     = bus.i_data_mem_addr - BASE_ADDR;
    widx    = off[AW+1:2];
    size    = size_e'(bus.i_data_mem_data_mask);
    illegal = 1'b0;
    case (size)
      SZ_BYTE: illegal = 1'b0;
      SZ_HALF: illegal = bus.i_data_mem_addr[0];
      SZ_WORD: illegal = |bus.i_data_mem_addr[1:0];
      default: illegal = 1'b1;
    endcase
    if ({1'b0, off} >= SPAN) illegal = 1'b1;
    if (rd && wr)            illegal = 1'b1;
  end

  // Acceptance is gated by reads still in the pipe rather than by the busy output,
  // so a held request is taken on the edge that ends the last busy cycle.
  always_comb begin
    in_flight = 1'b0;
    for (int unsigned j = 0; j + 1 < READ_LATENCY; j++) in_flight |= pv[j];
    bus.o_data_mem_busy = 1'b0;
    for (int unsigned j = 1; j < READ_LATENCY; j++) bus.o_data_mem_busy |= pv[j];
    accept = (rd | wr) & ~in_flight;
  end

  // Lane enables and replicated store data for the write merge.
  always_comb begin
    case (size)
      SZ_BYTE: begin
        lane_en = 4'b0001 << bus.i_data_mem_addr[1:0];
        wr_word = {4{bus.i_data_mem_write_data[7:0]}};
      end
      SZ_HALF: begin
        lane_en = bus.i_data_mem_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{bus.i_data_mem_write_data[15:0]}};
      end
      default: begin
        lane_en = 4'b1111;
        wr_word = bus.i_data_mem_write_data;
      end
    endcase
  end

  // Read extraction: shift the addressed lane down and zero-fill above the access size.
  always_comb begin
    rd_shift = mem[widx] >> {bus.i_data_mem_addr[1:0], 3'b000};
    case (size)
      SZ_BYTE: rd_extract = {24'h0, rd_shift[7:0]};
      SZ_HALF: rd_extract = {16'h0, rd_shift[15:0]};
      default: rd_extract = rd_shift;
    endcase
    if (illegal) rd_extract = '0;
  end

  // Word array: legal writes commit on the accepting edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (accept && wr && !illegal) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[widx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  // Read pipeline and registered outputs; illegal writes fault one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < READ_LATENCY; j++) begin
        pv[j] <= 1'b0;
        pf[j] <= 1'b0;
        pd[j] <= '0;
      end
      wr_fault_q                <= 1'b0;
      bus.o_data_mem_read_valid <= 1'b0;
      bus.o_data_mem_fault      <= 1'b0;
      bus.o_data_mem_read_data  <= '0;
    end else begin
      pv[0] <= accept & rd;
      pf[0] <= illegal;
      pd[0] <= rd_extract;
      for (int unsigned j = 1; j < READ_LATENCY; j++) begin
        pv[j] <= pv[j-1];
        pf[j] <= pf[j-1];
        pd[j] <= pd[j-1];
      end
      wr_fault_q                <= accept & wr & ~rd & illegal;
      bus.o_data_mem_read_valid <= pv[READ_LATENCY-1];
      bus.o_data_mem_fault      <= wr_fault_q | (pv[READ_LATENCY-1] & pf[READ_LATENCY-1]);
      if (pv[READ_LATENCY-1]) bus.o_data_mem_read_data <= pd[READ_LATENCY-1];
    end
  end

endmodule
